// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and constants for the serial-to-memory-bus debug bridge.
package uart_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_REQ,
    ST_WWAIT,
    ST_RWAIT,
    ST_RESP
  } state_t;

  localparam logic [7:0]  DEF_CMD_WRITE      = 8'h57;  // 'W'
  localparam logic [7:0]  DEF_CMD_READ       = 8'h52;  // 'R'
  localparam logic [7:0]  DEF_ACK_BYTE       = 8'h06;
  localparam logic [7:0]  DEF_NAK_BYTE       = 8'h15;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 120000; // 10 ms at 12 MHz

  // Bus addresses are word addresses; the low two bits are never driven.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// Byte-stream and memory-bus signals of the bridge, grouped for port use.
interface uart_bus_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_req;
  logic        bus_gnt;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;
  logic        busy;

  // Bridge side: initiator on the memory bus.
  modport master (
    input  rx_data, rx_valid, tx_ready, bus_gnt, mem_rdata, mem_rbusy, mem_wbusy,
    output tx_data, tx_valid, bus_req, mem_addr, mem_wdata, mem_wmask, mem_rstrb, busy
  );

  // Environment side: UART, arbiter and memory.
  modport slave (
    output rx_data, rx_valid, tx_ready, bus_gnt, mem_rdata, mem_rbusy, mem_wbusy,
    input  tx_data, tx_valid, bus_req, mem_addr, mem_wdata, mem_wmask, mem_rstrb, busy
  );
endinterface

// File: rtl/bridge_byte_shifter.sv
// 32-bit word assembled from / serialized into bytes, LSB first.
module bridge_byte_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  input  logic        i_advance,
  output logic [31:0] o_word,
  output logic [7:0]  o_byte,
  output logic        o_last
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;

  // Load a whole word, insert a byte at the index, or step the index.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_idx  <= '0;
    end else if (i_shift) begin
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_idx                        <= r_idx + 2'd1;
    end else if (i_advance) begin
      r_idx <= r_idx + 2'd1;
    end else if (i_clear) begin
      r_idx <= '0;
    end
  end

  assign o_word = r_word;
  assign o_byte = r_word[{r_idx, 3'b000} +: 8];
  assign o_last = (r_idx == 2'd3);

endmodule

// File: rtl/uart_bus_bridge.sv
// Serial command parser that issues single-word bus reads/writes for a host.
module uart_bus_bridge
  import uart_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [7:0]  CMD_WRITE      = DEF_CMD_WRITE,
  parameter logic [7:0]  CMD_READ       = DEF_CMD_READ,
  parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
  parameter logic [7:0]  NAK_BYTE       = DEF_NAK_BYTE
) (
  input logic              clk,
  input logic              reset,
  uart_bus_bridge_if.master bus
);

  state_t      r_state, w_next;
  logic        r_is_write;
  logic [31:0] r_tmo;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_wmask;
  logic        r_rstrb;
  logic        r_resp_one;

  logic        w_is_cmd, w_collect, w_tmo_hit, w_hs, w_resp_done;
  logic        w_addr_clear, w_addr_shift, w_data_clear, w_data_shift;
  logic        w_resp_load;
  logic [31:0] w_resp_word;

  logic [31:0] w_addr_word, w_data_word;
  logic        w_addr_last, w_data_last, w_resp_last;
  logic [7:0]  w_resp_byte;
  logic [7:0]  w_addr_byte_unused, w_data_byte_unused;
  logic [31:0] w_resp_word_unused;

  assign w_is_cmd    = (bus.rx_data == CMD_WRITE) || (bus.rx_data == CMD_READ);
  assign w_collect   = (r_state == ST_ADDR) || (r_state == ST_DATA);
  assign w_tmo_hit   = w_collect && !bus.rx_valid && ((r_tmo + 32'd1) == TIMEOUT_CYCLES);
  assign w_hs        = (r_state == ST_RESP) && bus.tx_ready;
  assign w_resp_done = r_resp_one || w_resp_last;

  bridge_byte_shifter u_addr (
    .clk(clk), .reset(reset),
    .i_clear(w_addr_clear), .i_load(1'b0), .i_word('0),
    .i_shift(w_addr_shift), .i_byte(bus.rx_data), .i_advance(1'b0),
    .o_word(w_addr_word), .o_byte(w_addr_byte_unused), .o_last(w_addr_last)
  );

  bridge_byte_shifter u_wdata (
    .clk(clk), .reset(reset),
    .i_clear(w_data_clear), .i_load(1'b0), .i_word('0),
    .i_shift(w_data_shift), .i_byte(bus.rx_data), .i_advance(1'b0),
    .o_word(w_data_word), .o_byte(w_data_byte_unused), .o_last(w_data_last)
  );

  bridge_byte_shifter u_resp (
    .clk(clk), .reset(reset),
    .i_clear(1'b0), .i_load(w_resp_load), .i_word(w_resp_word),
    .i_shift(1'b0), .i_byte('0), .i_advance(w_hs),
    .o_word(w_resp_word_unused), .o_byte(w_resp_byte), .o_last(w_resp_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state and shifter control.
  always_comb begin
    w_next       = r_state;
    w_addr_clear = 1'b0;
    w_addr_shift = 1'b0;
    w_data_clear = 1'b0;
    w_data_shift = 1'b0;
    w_resp_load  = 1'b0;
    w_resp_word  = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_addr_clear = 1'b1;
        w_data_clear = 1'b1;
        if (bus.rx_valid) begin
          if (w_is_cmd) begin
            w_next = ST_ADDR;
          end else begin
            w_resp_load = 1'b1;
            w_resp_word = {24'h0, NAK_BYTE};
            w_next      = ST_RESP;
          end
        end
      end
      ST_ADDR: begin
        w_addr_shift = bus.rx_valid;
        if (bus.rx_valid && w_addr_last) w_next = r_is_write ? ST_DATA : ST_REQ;
        else if (w_tmo_hit)              w_next = ST_IDLE;
      end
      ST_DATA: begin
        w_data_shift = bus.rx_valid;
        if (bus.rx_valid && w_data_last) w_next = ST_REQ;
        else if (w_tmo_hit)              w_next = ST_IDLE;
      end
      ST_REQ: begin
        if (bus.bus_gnt) w_next = r_is_write ? ST_WWAIT : ST_RWAIT;
      end
      ST_WWAIT: begin
        if (!bus.mem_wbusy) begin
          w_resp_load = 1'b1;
          w_resp_word = {24'h0, ACK_BYTE};
          w_next      = ST_RESP;
        end
      end
      ST_RWAIT: begin
        if (!bus.mem_rbusy) begin
          w_resp_load = 1'b1;
          w_resp_word = bus.mem_rdata;
          w_next      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (w_hs && w_resp_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Inter-byte timeout counter, live only while collecting a packet.
  always_ff @(posedge clk) begin
    if (reset)                              r_tmo <= '0;
    else if (!w_collect || bus.rx_valid || w_tmo_hit) r_tmo <= '0;
    else                                    r_tmo <= r_tmo + 32'd1;
  end

  // Command kind and response length.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_write <= 1'b0;
      r_resp_one <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.rx_valid) r_is_write <= (bus.rx_data == CMD_WRITE);
      if (w_resp_load)                        r_resp_one <= (r_state != ST_RWAIT);
    end
  end

  // Bus address and one-cycle strobes; the strobe follows the grant by a cycle
  // so that the registered address is already valid when it fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr <= '0;
      r_wmask    <= '0;
      r_rstrb    <= 1'b0;
    end else begin
      if (r_state == ST_REQ || r_state == ST_WWAIT || r_state == ST_RWAIT)
        r_mem_addr <= word_align(w_addr_word);
      r_wmask <= (r_state == ST_REQ && bus.bus_gnt && r_is_write)  ? '1 : '0;
      r_rstrb <= (r_state == ST_REQ && bus.bus_gnt && !r_is_write);
    end
  end

  assign bus.tx_data   = w_resp_byte;
  assign bus.tx_valid  = (r_state == ST_RESP);
  assign bus.bus_req   = (r_state == ST_REQ) || (r_state == ST_WWAIT) || (r_state == ST_RWAIT);
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = w_data_word;
  assign bus.mem_wmask = r_wmask;
  assign bus.mem_rstrb = r_rstrb;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Debug/loader bus initiator: the other end of the peripheral bus that the peripherals (uart, mult, RAM) answer.
- Consumes a received byte stream from a UART receiver and parses fixed-format command packets.
- Issues single-word read/write transactions on the FemtoRV-style memory bus after arbitration grant.
- Returns ACK or read data as a transmit byte stream. Lets a host load and inspect RAM over serial while the CPU is held off.

Parameters:
TIMEOUT_CYCLES, 120000, max idle clocks between packet bytes before abort (10 ms at 12 MHz)
CMD_WRITE, 8'h57, command byte for word write ('W')
CMD_READ, 8'h52, command byte for word read ('R')
ACK_BYTE, 8'h06, write-complete response
NAK_BYTE, 8'h15, unknown-command response

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid, held until tx_ready
tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready
bus_req  out  1  request bus ownership
bus_gnt  in  1  ownership granted (CPU held)
mem_addr  out  32  word address, [1:0] always 2'b00
mem_wdata  out  32  write data
mem_wmask  out  4  byte write enables
mem_rstrb  out  1  read strobe
mem_rdata  in  32  read data
mem_rbusy  in  1  read not yet complete
mem_wbusy  in  1  write not yet complete
busy  out  1  high whenever state != IDLE

Behaviour:
- One clock: clk. Reset is synchronous and active-high (reset). On reset:
  - state=IDLE.
  - tx_valid, bus_req, mem_rstrb, busy = 0; mem_wmask=0.
  - mem_addr, mem_wdata, tx_data = 0.
  - Byte counter and timeout counter = 0.
- Reset mid-transaction aborts immediately: bus_req drops the next edge and no partial response is sent.
- Packets:
  - Write: CMD_WRITE, A0..A3 (address LSB first), D0..D3 (data LSB first). Response: ACK_BYTE.
  - Read: CMD_READ, A0..A3. Response: 4 data bytes, LSB first.
- States:
  - IDLE:
    - rx_valid with CMD_WRITE or CMD_READ: latch command, go to ADDR.
    - rx_valid with any other byte: load NAK_BYTE, go to RESP.
  - ADDR: collect 4 bytes into the address register. After the 4th byte: write goes to DATA, read goes to REQ.
  - DATA: collect 4 bytes into mem_wdata, then go to REQ.
  - REQ: bus_req=1, wait for bus_gnt (no timeout).
    - Write: drive mem_wmask=4'hF for exactly one cycle, go to WWAIT.
    - Read: drive mem_rstrb=1 for exactly one cycle, go to RWAIT.
  - WWAIT: on the first cycle with mem_wbusy=0, load ACK_BYTE and go to RESP.
  - RWAIT: on the first cycle with mem_rbusy=0, capture mem_rdata and go to RESP with 4 bytes queued.
  - RESP:
    - bus_req deasserts on entry.
    - Present bytes in order; each byte is held until tx_valid&tx_ready.
    - Next byte is presented no earlier than the following cycle.
    - After the last handshake, go to IDLE.
- mem_addr is driven only while in REQ/WWAIT/RWAIT; otherwise it stays at its last value. mem_addr[1:0] is forced to 2'b00 regardless of A0[1:0].
- Timeout:
  - In ADDR/DATA, a counter increments each cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYCLES sends the state to IDLE silently.
- rx_valid outside IDLE/ADDR/DATA is dropped; no queueing.
- Latency: last packet byte, then REQ next cycle. With bus_gnt already high and zero busy, the memory strobe occurs one cycle after entering REQ.

Decomposition:
- Shared package uart_bus_pkg:
  - State enum.
  - Command and response byte constants.
  - TIMEOUT default.
- One natural sub-module: bridge_byte_shifter. It handles 4-byte LSB-first assemble/serialize with a 2-bit index, and is used for address, write data and read data.

Test Plan:
- Write: bus_gnt=1, bytes 57 00 10 00 00 EF BE AD DE → one cycle with mem_addr=0x00001000, mem_wdata=0xDEADBEEF, mem_wmask=F; tx byte 06.
- Read: mem_rdata=0x12345678, bytes 52 04 10 00 00 → mem_rstrb one cycle at addr 0x00001004; tx 78 56 34 12 in order. Stall with tx_ready=0 for 5 cycles per byte and check no byte is lost or repeated.
- Unknown command 0xAA → tx 15, busy returns to 0, no bus activity; a following valid read completes normally.
- Timeout: TIMEOUT_CYCLES=16, send 57 00 then nothing for 16 cycles → state IDLE, no bus_req; the next 52 starts a new packet.
- Grant and busy: bus_gnt low for 10 cycles then high, mem_rbusy high 3 cycles → mem_rstrb pulse after grant, data captured on the first rbusy=0 cycle, correct bytes sent.
- Reset mid-RESP after the 2nd read byte → tx_valid=0, bus_req=0, busy=0 next cycle; no remaining bytes sent.
